// File: rtl/game_timer_ctrl_pkg.sv
// Shared definitions for the mm:ss play timer: run-state encoding and BCD time layout.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [15:0] BCD_MAX  = 16'h9959;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

    typedef struct packed {
        logic [3:0] m_tens;
        logic [3:0] m_ones;
        logic [3:0] s_tens;
        logic [3:0] s_ones;
    } bcd_time_t;

endpackage

// File: rtl/game_timer_ctrl_if.sv
// Command strobes in, timer/record status out, between game logic and the timer controller.
interface game_timer_ctrl_if;

    logic        start;
    logic        pause;
    logic        stop;
    logic        clear;
    logic [15:0] limit_bcd;
    logic [15:0] time_spent;
    logic [1:0]  state;
    logic        timeout;
    logic        timed_out;
    logic [15:0] best_time;
    logic        best_valid;

    modport master (
        output start, pause, stop, clear, limit_bcd,
        input  time_spent, state, timeout, timed_out, best_time, best_valid
    );

    modport slave (
        input  start, pause, stop, clear, limit_bcd,
        output time_spent, state, timeout, timed_out, best_time, best_valid
    );

endinterface

// File: rtl/game_timer_ctrl_bcd_time_inc.sv
// Combinational mm:ss BCD incrementer; holds at 99:59, at_max flags a result of 99:59.
module bcd_time_inc
    import timer_pkg::*;
(
    input  logic [15:0] cur,
    output logic [15:0] nxt,
    output logic        at_max
);

    bcd_time_t w_cur;
    bcd_time_t w_nxt;

    assign w_cur = cur;

    always_comb begin
        w_nxt = w_cur;
        if (cur != BCD_MAX) begin
            if (w_cur.s_ones != 4'd9) begin
                w_nxt.s_ones = w_cur.s_ones + 4'd1;
            end else begin
                w_nxt.s_ones = 4'd0;
                if (w_cur.s_tens != 4'd5) begin
                    w_nxt.s_tens = w_cur.s_tens + 4'd1;
                end else begin
                    w_nxt.s_tens = 4'd0;
                    if (w_cur.m_ones != 4'd9) begin
                        w_nxt.m_ones = w_cur.m_ones + 4'd1;
                    end else begin
                        w_nxt.m_ones = 4'd0;
                        w_nxt.m_tens = w_cur.m_tens + 4'd1;
                    end
                end
            end
        end
    end

    assign nxt    = w_nxt;
    assign at_max = (nxt == BCD_MAX);

endmodule

// File: rtl/game_timer_ctrl.sv
// Play-timer run controller: idle/run/pause/done sequencing, seconds prescaler,
// BCD count with optional limit, and best-solve record.
module game_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_LEN = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    game_timer_ctrl_if.slave  bus
);

    localparam int unsigned     PW         = $clog2(TICK_LEN);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_LEN - 1);

    state_e        r_state;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_time;
    logic [15:0]   r_limit;
    logic          r_timeout;
    logic          r_timed_out;
    logic [15:0]   r_best;
    logic          r_best_valid;

    state_e        w_state_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [15:0]   w_time_nxt;
    logic [15:0]   w_limit_nxt;
    logic          w_timeout_nxt;
    logic          w_timed_out_nxt;
    logic [15:0]   w_best_nxt;
    logic          w_best_valid_nxt;

    logic          w_tick;
    logic [15:0]   w_inc;
    logic          w_inc_max;
    logic          w_term;
    logic          w_do_stop;
    logic          w_do_start;
    logic          w_restart;
    logic          w_do_pause;
    logic [15:0]   w_stop_time;

    bcd_time_inc u_inc (
        .cur    (r_time),
        .nxt    (w_inc),
        .at_max (w_inc_max)
    );

    // Command decode: clear > stop > start > pause, lower ones only where legal.
    assign w_do_stop  = !bus.clear && bus.stop && (r_state == RUNNING || r_state == PAUSED);
    assign w_do_start = !bus.clear && !w_do_stop && bus.start;
    assign w_restart  = w_do_start && (r_state != PAUSED);
    assign w_do_pause = !bus.clear && !w_do_stop && !bus.start && bus.pause
                        && (r_state == RUNNING || r_state == PAUSED);

    assign w_tick      = (r_state == RUNNING) && (r_presc == PRESC_LAST);
    assign w_term      = w_tick && (w_inc_max || (r_limit != BCD_ZERO && w_inc == r_limit));
    assign w_stop_time = w_tick ? w_inc : r_time;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = IDLE;
        end else if (w_do_stop) begin
            w_state_nxt = DONE;
        end else if (w_do_start) begin
            w_state_nxt = RUNNING;
        end else if (w_term) begin
            w_state_nxt = DONE;
        end else if (w_do_pause) begin
            w_state_nxt = (r_state == RUNNING) ? PAUSED : RUNNING;
        end
    end

    // Datapath next values; a tick coinciding with stop/pause is committed first.
    always_comb begin
        w_presc_nxt      = r_presc;
        w_time_nxt       = r_time;
        w_limit_nxt      = r_limit;
        w_timeout_nxt    = 1'b0;
        w_timed_out_nxt  = r_timed_out;
        w_best_nxt       = r_best;
        w_best_valid_nxt = r_best_valid;
        if (bus.clear) begin
            w_presc_nxt     = '0;
            w_time_nxt      = BCD_ZERO;
            w_timed_out_nxt = 1'b0;
        end else if (w_do_stop) begin
            w_time_nxt = w_stop_time;
            if (!r_best_valid || w_stop_time < r_best) begin
                w_best_nxt       = w_stop_time;
                w_best_valid_nxt = 1'b1;
            end
        end else if (w_restart) begin
            w_presc_nxt     = '0;
            w_time_nxt      = BCD_ZERO;
            w_limit_nxt     = bus.limit_bcd;
            w_timed_out_nxt = 1'b0;
        end else if (r_state == RUNNING) begin
            w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                w_time_nxt = w_inc;
            end
            if (w_term) begin
                w_timeout_nxt   = 1'b1;
                w_timed_out_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc      <= '0;
            r_time       <= BCD_ZERO;
            r_limit      <= BCD_ZERO;
            r_timeout    <= 1'b0;
            r_timed_out  <= 1'b0;
            r_best       <= BCD_ZERO;
            r_best_valid <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_time       <= w_time_nxt;
            r_limit      <= w_limit_nxt;
            r_timeout    <= w_timeout_nxt;
            r_timed_out  <= w_timed_out_nxt;
            r_best       <= w_best_nxt;
            r_best_valid <= w_best_valid_nxt;
        end
    end

    assign bus.time_spent = r_time;
    assign bus.state      = r_state;
    assign bus.timeout    = r_timeout;
    assign bus.timed_out  = r_timed_out;
    assign bus.best_time  = r_best;
    assign bus.best_valid = r_best_valid;

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Run controller for the game's BCD mm:ss play timer. It sequences the timer through idle, run, pause and done phases. It owns the seconds prescaler and the BCD count, and it enforces an optional time limit. It also records the best solve time. It sits between the one-pulsed button/game-logic strobes and the seven-segment/VGA time display.

## Interface

- TICK_LEN, default 100_000_000, clock cycles per counted second (≥2).
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low; all state clears on a rising clk edge where rst==0.
- start  in  1  one-cycle pulse: begin a new run.
- pause  in  1  one-cycle pulse: toggle RUNNING/PAUSED.
- stop  in  1  one-cycle pulse: puzzle solved, end the run.
- clear  in  1  one-cycle pulse: abort to IDLE, zero time.
- limit_bcd  in  16  time limit, BCD {mXX,mX,sXX,sX}. 16'h0000 means no limit. Sampled only on an accepted start.
- time_spent  out  16  current BCD mm:ss.
- state  out  2  IDLE=0, RUNNING=1, PAUSED=2, DONE=3.
- timeout  out  1  one-cycle pulse when a run ends by limit or saturation.
- timed_out  out  1  level: last run ended by timeout; cleared on start/clear.
- best_time  out  16  best (smallest) solved time, BCD.
- best_valid  out  1  best_time holds a real record.

## Operation

- Reset values: state IDLE, time_spent 0, prescaler 0, latched limit 0, timeout 0, timed_out 0, best_time 0, best_valid 0.
- Command priority per cycle is clear > stop > start > pause. Only the highest-priority legal command acts.
- IDLE:
  - start → RUNNING.
  - On that edge: time_spent=0, prescaler=0, limit latched, timed_out=0.
- RUNNING:
  - The prescaler counts 0..TICK_LEN-1 and wraps.
  - tick = (prescaler==TICK_LEN-1) while RUNNING. On a tick, time_spent takes its BCD increment.
  - pause → PAUSED.
  - stop → DONE (solved).
  - start → restart as from IDLE.
- PAUSED:
  - Prescaler and time_spent are frozen; the sub-second phase is preserved.
  - pause or start → RUNNING, resuming with the prescaler unchanged. start does not restart here.
  - stop → DONE (solved).
- DONE:
  - Time is frozen.
  - start → restart as from IDLE.
  - pause is ignored.
- clear in any state → IDLE with time_spent=0, prescaler=0, timed_out=0. best_time and best_valid are retained.
- BCD increment:
  - sX 9→0 carries to sXX.
  - sXX 5→0 (with sX 9) carries to mX.
  - mX 9→0 carries to mXX.
  - Digits never leave 0..9 (sXX 0..5).
- Termination on tick: if the incremented value equals a nonzero latched limit, or equals 16'h9959, the state becomes DONE. timeout pulses on that edge and timed_out is set. The count never wraps past 99:59.
- Tick in the same cycle as stop or pause: the increment is committed, then the command applies.
- Tick reaching the limit in the same cycle as stop: treated as solved. No timeout; the best update uses the incremented value.
- Best record: on a solved entry to DONE, if !best_valid or final time < best_time, then best_time=final time and best_valid=1. Packed BCD compares correctly as unsigned binary.
- Timeout never updates the best record.
- Inputs are required to be single-cycle pulses; a held pause toggles every cycle.

## Timing

- Commands are registered: state and outputs change on the edge that samples the pulse. There is no extra pipeline.
- First increment: time_spent=16'h0001 exactly TICK_LEN edges after the edge that accepts start.
- Subsequent increments occur every TICK_LEN RUNNING cycles. Paused cycles do not count.
- timeout is high for exactly the one cycle following the terminating edge. It coincides with state==DONE and the final time_spent.
- A best_time update is visible on the same edge as the DONE transition.
- Reset asserted mid-run takes effect on the next edge regardless of commands.

## Structure

- Shared package timer_pkg holds:
  - State encoding constants IDLE/RUNNING/PAUSED/DONE.
  - BCD_MAX = 16'h9959.
  - BCD_ZERO.
- Sub-module bcd_time_inc: purely combinational mm:ss BCD incrementer with input cur[15:0] and outputs nxt[15:0] and at_max. It is reused by the display countdown logic.
- The controller contains the FSM, prescaler, limit/best registers and the compare logic.

## Test plan

All scenarios run with TICK_LEN=4.

1. Reset → hold rst=0 two cycles → state 0, time_spent 16'h0000, best_valid 0, timeout 0.
2. Carry → start, limit 0, run 240 cycles → time_spent 16'h0100 via 00:59→01:00; 16'h0009→16'h0010 seen at cycle 40.
3. Pause → start, pause at cycle 6, hold 10 cycles, pause → next increment lands 2 cycles after resume; time_spent=16'h0002 at resume+2.
4. Limit → limit_bcd 16'h0005, start → at edge 20 time_spent 16'h0005, state 3, timeout one cycle, timed_out 1, best_valid 0.
5. Best record → solve at 16'h0003, restart, solve at 16'h0002 → best 16'h0002; third solve at 16'h0004 → best stays 16'h0002. Also cover stop coinciding with tick.
6. Saturation and clear → run 24000 cycles, limit 0 → stops at 16'h9959 with timeout. clear mid-run → IDLE, time 0, best retained. start in PAUSED resumes rather than restarts.
